serial_comp1_addsub_ctrl: RTL and testbench

- Bit-serial sequencer for the existing combinational 1-bit one's-complement add/subtract cell.
- Cell behaviour:
  - `sinal`=0: full adder, s = a^b^cin, cout = carry.
  - `sinal`=1: full subtractor a−b−cin, s = a^b^cin, cout = borrow.
- Feeds the cell one bit pair per cycle, LSB first, and registers the carry/borrow between cycles.
- Performs the one's-complement end-around carry/borrow as a second pass.
- Delivers a WIDTH-bit result with an overflow flag.

---
 rtl/serial_comp1_addsub_ctrl.sv | 163 ++++++++++++++++
 tb/tb_serial_comp1_addsub_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_comp1_addsub_ctrl.sv
// serial_comp1_addsub_ctrl
// Bit-serial sequencer for an external combinational 1-bit one's-complement
// add/subtract cell. Operands are fed LSB first, one bit pair per cycle, with
// the carry/borrow registered between cycles. If the first pass ends with a
// carry/borrow out, a second pass adds/subtracts it back in (end-around).
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start               request, only looked at in IDLE
//   sinal               0 = a+b, 1 = a-b (latched on start)
//   op_a, op_b          one's-complement operands (latched on start)
//   busy                high during PASS1/PASS2
//   done                one-cycle pulse, result/overflow valid
//   result, overflow    last result and signed overflow, held until next DONE
//   cell_a/b/cin/sinal  drive to the cell
//   cell_s, cell_cout   cell sum/difference bit and carry/borrow out
//
// state | meaning
// IDLE  | waiting for start
// PASS1 | operand bits through the cell, LSB first
// PASS2 | end-around: partial result through the cell with b=0, cin=1 first
// DONE  | result/overflow registered, done pulse

module serial_comp1_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sinal,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             cell_a,
  output logic             cell_b,
  output logic             cell_cin,
  output logic             cell_sinal,
  input  logic             cell_s,
  input  logic             cell_cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sb, r;
  logic [WIDTH-1:0] r_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sinal_q;
  logic             a_msb, b_msb;
  logic             ovf_next;
  logic             last_bit;

  // Bit counter runs down; the terminal count marks the MSB cycle of a pass.
  assign last_bit = (cnt == '0);
  assign r_next   = {cell_s, r[WIDTH-1:1]};

  always_comb begin
    if (sinal_q) begin
      ovf_next = (a_msb != b_msb) && (r_next[WIDTH-1] != a_msb);
    end else begin
      ovf_next = (a_msb == b_msb) && (r_next[WIDTH-1] != a_msb);
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    cell_a     = 1'b0;
    cell_b     = 1'b0;
    cell_cin   = 1'b0;
    cell_sinal = sinal_q;
    case (state)
      IDLE: begin
        if (start) state_next = PASS1;
      end
      PASS1: begin
        busy     = 1'b1;
        cell_a   = sa[0];
        cell_b   = sb[0];
        cell_cin = carry;
        if (last_bit) state_next = cell_cout ? PASS2 : DONE;
      end
      PASS2: begin
        busy     = 1'b1;
        cell_a   = r[0];
        cell_cin = carry;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      r        <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sinal_q  <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            sa      <= op_a;
            sb      <= op_b;
            sinal_q <= sinal;
            a_msb   <= op_a[WIDTH-1];
            b_msb   <= op_b[WIDTH-1];
            carry   <= 1'b0;
            cnt     <= CNT_LOAD;
            r       <= '0;
          end
        end
        PASS1: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          r     <= r_next;
          carry <= cell_cout;
          cnt   <= cnt - CW'(1);
          if (last_bit) begin
            if (cell_cout) begin
              cnt <= CNT_LOAD;
            end else begin
              result   <= r_next;
              overflow <= ovf_next;
            end
          end
        end
        PASS2: begin
          r     <= r_next;
          carry <= cell_cout;
          cnt   <= cnt - CW'(1);
          // Final carry/borrow of this pass is dropped.
          if (last_bit) begin
            result   <= r_next;
            overflow <= ovf_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_comp1_addsub_ctrl.sv
module tb_serial_comp1_addsub_ctrl;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sinal = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy, done, overflow;
  logic [W-1:0] result;
  logic         cell_a, cell_b, cell_cin, cell_sinal, cell_s, cell_cout;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  serial_comp1_addsub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sinal(sinal),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .result(result), .overflow(overflow),
    .cell_a(cell_a), .cell_b(cell_b), .cell_cin(cell_cin),
    .cell_sinal(cell_sinal), .cell_s(cell_s), .cell_cout(cell_cout)
  );

  always #5 clk = ~clk;

  // The one's-complement add/subtract cell.
  assign cell_s    = cell_a ^ cell_b ^ cell_cin;
  assign cell_cout = cell_sinal ? ((~cell_a & cell_b) | (~(cell_a ^ cell_b) & cell_cin))
                                : ((cell_a & cell_b) | (cell_cin & (cell_a ^ cell_b)));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: arithmetic result, latency and per-bit carries.
  bit m_active = 0, m_done = 0, m_sinal = 0, m_ovf = 0, p_ovf = 0;
  int m_cyc = 0, m_len = 0, m_a = 0, m_b = 0, m_r1 = 0, m_res = 0, p_res = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_done = 0; m_res = 0; m_ovf = 0; m_sinal = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_active) begin
      if (m_cyc == m_len - 1) begin
        m_active = 0; m_done = 1; m_res = p_res; m_ovf = p_ovf;
      end else begin
        m_cyc++;
      end
    end else if (start) begin
      int am, bm, rm;
      m_active = 1; m_cyc = 0;
      m_a = int'(op_a); m_b = int'(op_b); m_sinal = sinal;
      if (!sinal) begin
        if (m_a + m_b > MASK) begin
          m_r1 = (m_a + m_b) & MASK; p_res = m_r1 + 1; m_len = 2 * W;
        end else begin
          m_r1 = m_a + m_b; p_res = m_r1; m_len = W;
        end
      end else begin
        if (m_a < m_b) begin
          m_r1 = m_a - m_b + (1 << W); p_res = m_r1 - 1; m_len = 2 * W;
        end else begin
          m_r1 = m_a - m_b; p_res = m_r1; m_len = W;
        end
      end
      am = (m_a >> (W - 1)) & 1;
      bm = (m_b >> (W - 1)) & 1;
      rm = (p_res >> (W - 1)) & 1;
      p_ovf = sinal ? ((am != bm) && (rm != am)) : ((am == bm) && (rm != am));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit ea, eb, ec;
      int i, lm;
      ea = 0; eb = 0; ec = 0;
      if (m_active) begin
        if (m_cyc < W) begin
          i = m_cyc; lm = (1 << i) - 1;
          ea = bit'((m_a >> i) & 1);
          eb = bit'((m_b >> i) & 1);
          ec = m_sinal ? ((m_a & lm) < (m_b & lm)) : bit'((((m_a & lm) + (m_b & lm)) >> i) & 1);
        end else begin
          i = m_cyc - W; lm = (1 << i) - 1;
          ea = bit'((m_r1 >> i) & 1);
          ec = m_sinal ? ((m_r1 & lm) == 0) : bit'((((m_r1 & lm) + 1) >> i) & 1);
        end
      end
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(m_done));
      chk("result", 32'(result), 32'(m_res));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("cell_a", 32'(cell_a), 32'(ea));
      chk("cell_b", 32'(cell_b), 32'(eb));
      chk("cell_cin", 32'(cell_cin), 32'(ec));
      chk("cell_sinal", 32'(cell_sinal), 32'(m_sinal));
    end
  end

  task automatic run_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_res, input bit exp_ovf, input int exp_lat);
    int lat;
    @(posedge clk); #1;
    sinal = s; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("op_result", 32'(result), 32'(exp_res));
    chk("op_overflow", 32'(overflow), 32'(exp_ovf));
  endtask

  initial begin
    int dn;
    logic [W-1:0] res_seen;
    @(posedge clk); #1;
    chk_en = 1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    run_op(1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 9);
    run_op(1'b0, 8'h05, 8'hFC, 8'h02, 1'b0, 17);
    run_op(1'b1, 8'h05, 8'h03, 8'h02, 1'b0, 9);
    run_op(1'b1, 8'h03, 8'h05, 8'hFD, 1'b0, 17);
    run_op(1'b0, 8'h7F, 8'h01, 8'h80, 1'b1, 9);
    run_op(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 9);
    run_op(1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 17);

    // start pulsed with new operands during PASS1 is ignored
    @(posedge clk); #1;
    sinal = 1'b0; op_a = 8'h05; op_b = 8'h03; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dn = 0; res_seen = '0;
    for (int k = 0; k < 25; k++) begin
      if (k == 3) begin
        sinal = 1'b1; op_a = 8'h7F; op_b = 8'h01; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        dn++; res_seen = result;
      end
    end
    chk("ignored_start_done_count", 32'(dn), 32'd1);
    chk("ignored_start_result", 32'(res_seen), 32'h08);

    // start held: next op accepted at the first IDLE cycle after DONE
    sinal = 1'b0; op_a = 8'h05; op_b = 8'h03; start = 1'b1;
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    start = 1'b0;
    chk("held_start_done_count", 32'(dn), 32'd2);
    for (int k = 0; k < 20; k++) @(posedge clk);

    // reset during PASS2
    @(posedge clk); #1;
    sinal = 1'b0; op_a = 8'h05; op_b = 8'hFC; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
    end
    chk("pass2_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    run_op(1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 9);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
